// File: rtl/InstructionSetPkg.sv
// Shared instruction-set definitions: data/immediate widths, operation codes and ALU flags.
package InstructionSetPkg;

    localparam int unsigned DataWidth      = 16;
    localparam int unsigned ImmediateWidth = 8;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_LIL  = 3'd1,
        OP_LIH  = 3'd2,
        OP_MOVE = 3'd3,
        OP_ADD  = 3'd4,
        OP_ADC  = 3'd5,
        OP_NAND = 3'd6,
        OP_XOR  = 3'd7
    } eOperation;

    typedef struct packed {
        logic Negative;
        logic Zero;
        logic Overflow;
        logic Carry;
    } sFlags;

endpackage

// File: rtl/execution_controller_if.sv
// Instruction, ALU, result and debug signals of the execution controller.
interface execution_controller_if;
    import InstructionSetPkg::*;

    localparam int unsigned IdxWidth = 3;

    logic                      InValid;
    logic                      InReady;
    eOperation                 InOp;
    logic [IdxWidth-1:0]       InDestIdx;
    logic [IdxWidth-1:0]       InSrcIdx;
    logic [ImmediateWidth-1:0] InImmIn;

    eOperation                 AluOperation;
    sFlags                     AluInFlags;
    logic [ImmediateWidth-1:0] AluInImm;
    logic [DataWidth-1:0]      AluInSrc;
    logic [DataWidth-1:0]      AluInDest;
    logic [DataWidth-1:0]      AluOutDest;
    sFlags                     AluOutFlags;

    logic                      OutValid;
    logic                      OutReady;
    logic [DataWidth-1:0]      OutResult;
    sFlags                     OutFlags;
    logic [IdxWidth-1:0]       OutIdx;

    logic [IdxWidth-1:0]       RdIdx;
    logic [DataWidth-1:0]      RdData;
    logic [15:0]               RetireCount;

    modport slave (
        input  InValid, InOp, InDestIdx, InSrcIdx, InImmIn,
        input  AluOutDest, AluOutFlags,
        input  OutReady, RdIdx,
        output InReady,
        output AluOperation, AluInFlags, AluInImm, AluInSrc, AluInDest,
        output OutValid, OutResult, OutFlags, OutIdx,
        output RdData, RetireCount
    );

    modport master (
        output InValid, InOp, InDestIdx, InSrcIdx, InImmIn,
        output AluOutDest, AluOutFlags,
        output OutReady, RdIdx,
        input  InReady,
        input  AluOperation, AluInFlags, AluInImm, AluInSrc, AluInDest,
        input  OutValid, OutResult, OutFlags, OutIdx,
        input  RdData, RetireCount
    );

endinterface

// File: rtl/execution_controller.sv
// Single-issue execution controller: accepts one instruction, reads operands, drives the ALU,
// writes the result back and holds it on a valid/ready output until the consumer takes it.
module execution_controller
    import InstructionSetPkg::*;
(
    input  logic                Clock,
    input  logic                nReset,
    execution_controller_if.slave bus
);

    localparam int unsigned RegCount   = 8;
    localparam int unsigned IdxWidth   = 3;
    localparam int unsigned CountWidth = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        EXEC  = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic                      w_accept;
    logic                      w_read;
    logic                      w_exec;
    logic                      w_retire;

    eOperation                 r_op;
    logic [IdxWidth-1:0]       r_dest_idx;
    logic [IdxWidth-1:0]       r_src_idx;
    logic [ImmediateWidth-1:0] r_imm;
    logic [DataWidth-1:0]      r_src_op;
    logic [DataWidth-1:0]      r_dest_op;
    sFlags                     r_flag_op;

    logic [DataWidth-1:0]      r_regs [RegCount];
    sFlags                     r_flags;

    logic                      r_out_valid;
    logic [DataWidth-1:0]      r_out_result;
    sFlags                     r_out_flags;
    logic [IdxWidth-1:0]       r_out_idx;
    logic [CountWidth-1:0]     r_retire_count;

    // State register
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and per-state strobes
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_read       = 1'b0;
        w_exec       = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.InValid) begin
                    w_accept     = 1'b1;
                    w_state_next = READ;
                end
            end
            READ: begin
                w_read       = 1'b1;
                w_state_next = EXEC;
            end
            EXEC: begin
                w_exec       = 1'b1;
                w_state_next = WRITE;
            end
            WRITE: begin
                if (r_out_valid && bus.OutReady) begin
                    w_retire     = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Instruction latch and operand capture; In* ports are only sampled on accept
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_op       <= OP_NOP;
            r_dest_idx <= '0;
            r_src_idx  <= '0;
            r_imm      <= '0;
            r_src_op   <= '0;
            r_dest_op  <= '0;
            r_flag_op  <= '0;
        end else begin
            if (w_accept) begin
                r_op       <= bus.InOp;
                r_dest_idx <= bus.InDestIdx;
                r_src_idx  <= bus.InSrcIdx;
                r_imm      <= bus.InImmIn;
            end
            if (w_read) begin
                r_src_op  <= r_regs[r_src_idx];
                r_dest_op <= r_regs[r_dest_idx];
                r_flag_op <= r_flags;
            end
        end
    end

    // Register file and flags: the only write port is the EXEC -> WRITE edge
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            for (int unsigned i = 0; i < RegCount; i++) begin
                r_regs[i] <= '0;
            end
            r_flags <= '0;
        end else if (w_exec) begin
            r_regs[r_dest_idx] <= bus.AluOutDest;
            r_flags            <= bus.AluOutFlags;
        end
    end

    // Retired result holding register and retire counter
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_out_valid    <= 1'b0;
            r_out_result   <= '0;
            r_out_flags    <= '0;
            r_out_idx      <= '0;
            r_retire_count <= '0;
        end else begin
            if (w_exec) begin
                r_out_valid  <= 1'b1;
                r_out_result <= bus.AluOutDest;
                r_out_flags  <= bus.AluOutFlags;
                r_out_idx    <= r_dest_idx;
            end
            if (w_retire) begin
                r_out_valid    <= 1'b0;
                r_retire_count <= r_retire_count + CountWidth'(1);
            end
        end
    end

    assign bus.InReady      = (r_state == IDLE);

    assign bus.AluOperation = r_op;
    assign bus.AluInFlags   = r_flag_op;
    assign bus.AluInImm     = r_imm;
    assign bus.AluInSrc     = r_src_op;
    assign bus.AluInDest    = r_dest_op;

    assign bus.OutValid     = r_out_valid;
    assign bus.OutResult    = r_out_result;
    assign bus.OutFlags     = r_out_flags;
    assign bus.OutIdx       = r_out_idx;
    assign bus.RetireCount  = r_retire_count;

    assign bus.RdData       = r_regs[bus.RdIdx];

endmodule

// File: tb/tb_execution_controller.sv
// Bench for execution_controller: stand-in ALU, transaction-level model checked every cycle,
// plus directed scenarios with hand-computed results.
module tb_execution_controller;
    import InstructionSetPkg::*;

    localparam logic [15:0] Preload = 16'hFFFA;

    typedef struct packed {
        sFlags       f;
        logic [15:0] d;
    } alu_res_t;

    logic        Clock  = 1'b0;
    logic        nReset = 1'b0;
    int          total  = 0;
    int          bad    = 0;
    int          preload_req = 0;

    logic [15:0] last_res;
    sFlags       last_flags;
    logic [2:0]  last_idx;
    alu_res_t    w_alu;

    // transaction-level model state
    logic [15:0] model_regs [8];
    sFlags       model_flags;
    logic [15:0] model_retire;
    bit          have_inst;
    bit          written;
    int          acc_cyc;
    eOperation   m_op;
    logic [2:0]  m_dst;
    logic [2:0]  m_src;
    logic [7:0]  m_imm;
    sFlags       m_fin;
    logic [15:0] m_din;
    logic [15:0] m_sin;
    alu_res_t    m_exp;

    execution_controller_if bus ();

    execution_controller dut (
        .Clock  (Clock),
        .nReset (nReset),
        .bus    (bus)
    );

    always #5 Clock = ~Clock;

    function automatic alu_res_t alu(input eOperation op, input logic [15:0] d, input logic [15:0] s,
                                     input logic [7:0] imm, input sFlags fi);
        alu_res_t    r;
        logic [16:0] sum;
        r.f = fi;
        r.d = d;
        sum = 17'd0;
        case (op)
            OP_LIL:  r.d = {d[15:8], imm};
            OP_LIH:  r.d = {imm, d[7:0]};
            OP_MOVE: r.d = s;
            OP_ADD, OP_ADC: begin
                sum = {1'b0, d} + {1'b0, s} + ((op == OP_ADC && fi.Carry) ? 17'd1 : 17'd0);
                r.d = sum[15:0];
                r.f.Carry    = sum[16];
                r.f.Overflow = (d[15] == s[15]) && (sum[15] != d[15]);
                r.f.Zero     = (sum[15:0] == 16'd0);
                r.f.Negative = sum[15];
            end
            OP_NAND, OP_XOR: begin
                r.d = (op == OP_NAND) ? ~(d & s) : (d ^ s);
                r.f.Zero     = (r.d == 16'd0);
                r.f.Negative = r.d[15];
            end
            default: r.d = d;
        endcase
        return r;
    endfunction

    always_comb w_alu = alu(bus.AluOperation, bus.AluInDest, bus.AluInSrc, bus.AluInImm, bus.AluInFlags);
    assign bus.AluOutDest  = w_alu.d;
    assign bus.AluOutFlags = w_alu.f;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model; sampled on the falling edge
    initial begin : compare
        int cyc;
        int preload_seen;
        cyc = 0;
        preload_seen = 0;
        forever begin
            @(negedge Clock);
            cyc++;
            if (!nReset) begin
                for (int i = 0; i < 8; i++) model_regs[i] = 16'd0;
                model_flags  = '0;
                model_retire = 16'd0;
                have_inst    = 1'b0;
                written      = 1'b0;
                check("rst_in_ready",  {31'b0, bus.InReady},  32'd1);
                check("rst_out_valid", {31'b0, bus.OutValid}, 32'd0);
                check("rst_retire",    {16'b0, bus.RetireCount}, 32'd0);
                check("rst_rd_data",   {16'b0, bus.RdData},   32'd0);
            end else begin
                if (preload_req != preload_seen) begin
                    preload_seen = preload_req;
                    model_retire = Preload;
                end
                if (have_inst && !written && cyc == acc_cyc + 3) begin
                    model_regs[m_dst] = m_exp.d;
                    model_flags       = m_exp.f;
                    written           = 1'b1;
                end
                check("in_ready",  {31'b0, bus.InReady},  {31'b0, !have_inst});
                check("out_valid", {31'b0, bus.OutValid}, {31'b0, written});
                if (written) begin
                    check("out_result", {16'b0, bus.OutResult}, {16'b0, m_exp.d});
                    check("out_flags",  {28'b0, bus.OutFlags},  {28'b0, m_exp.f});
                    check("out_idx",    {29'b0, bus.OutIdx},    {29'b0, m_dst});
                end
                if (have_inst && cyc == acc_cyc + 2) begin
                    check("alu_op",    {29'b0, bus.AluOperation}, {29'b0, m_op});
                    check("alu_src",   {16'b0, bus.AluInSrc},     {16'b0, m_sin});
                    check("alu_dest",  {16'b0, bus.AluInDest},    {16'b0, m_din});
                    check("alu_flags", {28'b0, bus.AluInFlags},   {28'b0, m_fin});
                    check("alu_imm",   {24'b0, bus.AluInImm},     {24'b0, m_imm});
                end
                check("rd_data", {16'b0, bus.RdData}, {16'b0, model_regs[bus.RdIdx]});
                check("retire",  {16'b0, bus.RetireCount}, {16'b0, model_retire});
                if (written && bus.OutReady) begin
                    have_inst    = 1'b0;
                    written      = 1'b0;
                    model_retire = model_retire + 16'd1;
                end else if (!have_inst && bus.InValid) begin
                    have_inst = 1'b1;
                    acc_cyc   = cyc;
                    m_op      = bus.InOp;
                    m_dst     = bus.InDestIdx;
                    m_src     = bus.InSrcIdx;
                    m_imm     = bus.InImmIn;
                    m_fin     = model_flags;
                    m_din     = model_regs[m_dst];
                    m_sin     = model_regs[m_src];
                    m_exp     = alu(m_op, m_din, m_sin, m_imm, m_fin);
                end
            end
        end
    end

    task automatic scramble();
        bus.InOp      = eOperation'($urandom_range(0, 7));
        bus.InDestIdx = 3'($urandom_range(0, 7));
        bus.InSrcIdx  = 3'($urandom_range(0, 7));
        bus.InImmIn   = 8'($urandom_range(0, 255));
    endtask

    // Offer one instruction; returns 2 ns after the accepting edge
    task automatic issue(input eOperation op, input logic [2:0] dst, input logic [2:0] src, input logic [7:0] imm);
        int n;
        n = 0;
        while (!bus.InReady && n < 40) begin
            @(posedge Clock); #2;
            n++;
        end
        check("issue_ready_timeout", {31'b0, bus.InReady}, 32'd1);
        bus.InValid   = 1'b1;
        bus.InOp      = op;
        bus.InDestIdx = dst;
        bus.InSrcIdx  = src;
        bus.InImmIn   = imm;
        @(posedge Clock); #2;
        bus.InValid = 1'b0;
        bus.RdIdx   = 3'($urandom_range(0, 7));
        scramble();
    endtask

    // Issue, capture the retired outputs, and wait until the controller is ready again
    task automatic run(input eOperation op, input logic [2:0] dst, input logic [2:0] src, input logic [7:0] imm);
        int n;
        issue(op, dst, src, imm);
        n = 0;
        while (!bus.OutValid && n < 20) begin
            @(posedge Clock); #2;
            n++;
        end
        check("run_valid_timeout", {31'b0, bus.OutValid}, 32'd1);
        last_res   = bus.OutResult;
        last_flags = bus.OutFlags;
        last_idx   = bus.OutIdx;
        n = 0;
        while (!bus.InReady && n < 20) begin
            @(posedge Clock); #2;
            n++;
        end
        check("run_ready_timeout", {31'b0, bus.InReady}, 32'd1);
    endtask

    initial begin : stimulus
        bus.InValid  = 1'b0;
        bus.OutReady = 1'b1;
        bus.RdIdx    = 3'd0;
        bus.InOp     = OP_NOP;
        bus.InDestIdx = 3'd0;
        bus.InSrcIdx  = 3'd0;
        bus.InImmIn   = 8'd0;
        repeat (3) @(posedge Clock);
        #2;
        check("reset_ready_lit", {31'b0, bus.InReady}, 32'd1);
        check("reset_count_lit", {16'b0, bus.RetireCount}, 32'd0);
        nReset = 1'b1;
        @(posedge Clock); #2;

        // LIL R1 = 0x0055, valid after the third edge
        issue(OP_LIL, 3'd1, 3'd0, 8'h55);
        check("lil_not_valid_n1", {31'b0, bus.OutValid}, 32'd0);
        @(posedge Clock); #2;
        check("lil_not_valid_n2", {31'b0, bus.OutValid}, 32'd0);
        @(posedge Clock); #2;
        check("lil_valid_n3",  {31'b0, bus.OutValid},  32'd1);
        check("lil_result",    {16'b0, bus.OutResult}, 32'h0055);
        check("lil_idx",       {29'b0, bus.OutIdx},    32'd1);
        bus.RdIdx = 3'd1;
        #1;
        check("lil_rd_r1",     {16'b0, bus.RdData},    32'h0055);
        @(posedge Clock); #2;
        check("lil_retire",    {16'b0, bus.RetireCount}, 32'd1);
        check("lil_ready_n4",  {31'b0, bus.InReady},   32'd1);

        // NAND R2 <- R2 nand R1
        run(OP_LIL, 3'd1, 3'd0, 8'hFF);
        run(OP_LIL, 3'd2, 3'd0, 8'h0F);
        run(OP_LIH, 3'd2, 3'd0, 8'h0F);
        run(OP_NAND, 3'd2, 3'd1, 8'h00);
        check("nand_result", {16'b0, last_res},   32'hFFF0);
        check("nand_flags",  {28'b0, last_flags}, 32'b1000);
        bus.RdIdx = 3'd1;
        #1;
        check("nand_r1_kept", {16'b0, bus.RdData}, 32'h00FF);

        // ADC overflow into the sign bit, then flags carried to the next instruction
        run(OP_LIL, 3'd3, 3'd0, 8'hFF);
        run(OP_LIH, 3'd3, 3'd0, 8'h7F);
        run(OP_LIL, 3'd4, 3'd0, 8'h01);
        run(OP_ADC, 3'd3, 3'd4, 8'h00);
        check("adc_result", {16'b0, last_res},   32'h8000);
        check("adc_flags",  {28'b0, last_flags}, 32'b1010);
        run(OP_NOP, 3'd0, 3'd0, 8'h00);
        check("nop_flags_held", {28'b0, last_flags}, 32'b1010);
        run(OP_ADD, 3'd3, 3'd3, 8'h00);
        check("add_same_result", {16'b0, last_res},   32'h0000);
        check("add_same_flags",  {28'b0, last_flags}, 32'b0111);
        run(OP_ADC, 3'd1, 3'd1, 8'h00);
        check("adc_same_result", {16'b0, last_res},   32'h01FF);
        check("adc_same_flags",  {28'b0, last_flags}, 32'b0000);

        // Back-pressure: result held, InValid pulses ignored
        bus.OutReady = 1'b0;
        issue(OP_MOVE, 3'd7, 3'd1, 8'h00);
        @(posedge Clock); #2;
        @(posedge Clock); #2;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid",  {31'b0, bus.OutValid},  32'd1);
            check("bp_result", {16'b0, bus.OutResult}, 32'h01FF);
            check("bp_idx",    {29'b0, bus.OutIdx},    32'd7);
            check("bp_ready",  {31'b0, bus.InReady},   32'd0);
            bus.InValid = (i % 2 == 0);
            scramble();
            @(posedge Clock); #2;
        end
        bus.InValid  = 1'b0;
        bus.OutReady = 1'b1;
        @(posedge Clock); #2;
        check("bp_ready_after", {31'b0, bus.InReady},     32'd1);
        check("bp_retire",      {16'b0, bus.RetireCount}, 32'd13);

        // Reset while MOVE R5 <- R1 is in EXEC
        issue(OP_MOVE, 3'd5, 3'd1, 8'h00);
        @(posedge Clock); #2;
        nReset = 1'b0;
        repeat (2) @(posedge Clock);
        #2;
        nReset = 1'b1;
        repeat (3) @(posedge Clock);
        #2;
        bus.RdIdx = 3'd5;
        #1;
        check("rstmid_r5",     {16'b0, bus.RdData},      32'd0);
        check("rstmid_valid",  {31'b0, bus.OutValid},    32'd0);
        check("rstmid_retire", {16'b0, bus.RetireCount}, 32'd0);

        // Retire counter wrap
        force dut.r_retire_count = Preload;
        preload_req++;
        @(posedge Clock); #2;
        release dut.r_retire_count;
        for (int i = 0; i < 6; i++) run(OP_NOP, 3'd0, 3'd0, 8'($urandom_range(0, 255)));
        check("wrap_zero", {16'b0, bus.RetireCount}, 32'h0000);
        for (int i = 0; i < 2; i++) run(OP_XOR, 3'd6, 3'd6, 8'h00);
        check("wrap_two",  {16'b0, bus.RetireCount}, 32'h0002);

        repeat (3) @(posedge Clock);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
